// File: rtl/bcd_updown_counter.sv
// Parametrised N-digit packed-BCD up/down counter with load, clear, set-to-one,
// wrap or saturate at the terminal value, a registered terminal-event pulse and a
// combinational cascade carry for chaining wider counts.
module bcd_updown_counter #(
  parameter int unsigned DIGITS = 6,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  ce,
  input  logic                  dir,
  input  logic                  sclr,
  input  logic                  set_one,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  ceo,
  output logic                  ovf,
  output logic                  zero,
  output logic                  max
);

  localparam int unsigned W = 4 * DIGITS;

  function automatic logic [W-1:0] all_nines();
    logic [W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'd9;
    end
    return r;
  endfunction

  localparam logic [W-1:0] Nines = all_nines();
  localparam logic [W-1:0] One   = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] inc_val, dec_val, load_san;
  logic         carry, borrow;
  logic         ctl_act;

  // Single-cycle ripple of carry/borrow through all digits, plus load sanitising.
  always_comb begin
    inc_val  = cnt_q;
    dec_val  = cnt_q;
    load_san = load_val;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (cnt_q[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = cnt_q[4*k +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (cnt_q[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = cnt_q[4*k +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
      // Non-BCD digits clamp to 9 so cnt never holds an invalid code.
      if (load_val[4*k +: 4] > 4'd9) begin
        load_san[4*k +: 4] = 4'd9;
      end
    end
  end

  // Next-state selection in priority order: sclr, load, set_one, count step, hold.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (sclr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_san;
    end else if (set_one) begin
      cnt_d = One;
    end else if (ce) begin
      if (dir) begin
        if (max) begin
          ovf_d = 1'b1;
          cnt_d = WRAP ? '0 : cnt_q;
        end else begin
          cnt_d = inc_val;
        end
      end else begin
        if (zero) begin
          ovf_d = 1'b1;
          cnt_d = WRAP ? Nines : cnt_q;
        end else begin
          cnt_d = dec_val;
        end
      end
    end
  end

  // Count and overflow-pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Status flags and cascade enable; ceo fires regardless of WRAP.
  always_comb begin
    ctl_act = sclr | load | set_one;
    zero    = (cnt_q == '0);
    max     = (cnt_q == Nines);
    ceo     = ce & ~ctl_act & (dir ? max : zero);
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: a wrapping and a saturating instance share
// the same stimulus; an integer-arithmetic model predicts each edge's result into a
// queue that is popped and compared once the DUT has registered the step.
module tb_bcd_updown_counter;

  localparam int unsigned DIGITS = 6;
  localparam int          MAXV   = 999999;

  logic        clk = 1'b0;
  logic        nrst, ce, dir, sclr, set_one, load;
  logic [23:0] load_val;
  logic [23:0] cnt_w, cnt_s;
  logic        ceo_w, ceo_s, ovf_w, ovf_s, zero_w, zero_s, max_w, max_s;

  int checks   = 0;
  int failures = 0;

  int  m_cnt [2];
  bit  model_valid = 1'b0;
  logic [24:0] q_w [$];
  logic [24:0] q_s [$];

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(DIGITS), .WRAP(1'b1)) u_wrap (
    .clk(clk), .nrst(nrst), .ce(ce), .dir(dir), .sclr(sclr), .set_one(set_one),
    .load(load), .load_val(load_val), .cnt(cnt_w), .ceo(ceo_w), .ovf(ovf_w),
    .zero(zero_w), .max(max_w)
  );

  bcd_updown_counter #(.DIGITS(DIGITS), .WRAP(1'b0)) u_sat (
    .clk(clk), .nrst(nrst), .ce(ce), .dir(dir), .sclr(sclr), .set_one(set_one),
    .load(load), .load_val(load_val), .cnt(cnt_s), .ceo(ceo_s), .ovf(ovf_s),
    .zero(zero_s), .max(max_s)
  );

  function automatic int sanit(input logic [23:0] v);
    int r = 0;
    int p = 1;
    for (int k = 0; k < 6; k++) begin
      int d = int'(v[4*k +: 4]);
      if (d > 9) d = 9;
      r += d * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [23:0] int2bcd(input int n);
    logic [23:0] r = '0;
    int v = n;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic n, input logic c, input logic d, input logic s,
                      input logic o, input logic l, input logic [23:0] v);
    int          nxt;
    bit          nov;
    logic [24:0] e;
    nrst = n; ce = c; dir = d; sclr = s; set_one = o; load = l; load_val = v;
    #1;
    if (model_valid) begin
      check("w_zero", 24'(zero_w), 24'(m_cnt[0] == 0));
      check("w_max",  24'(max_w),  24'(m_cnt[0] == MAXV));
      check("w_ceo",  24'(ceo_w),  24'(c & ~s & ~l & ~o & (d ? m_cnt[0] == MAXV : m_cnt[0] == 0)));
      check("s_zero", 24'(zero_s), 24'(m_cnt[1] == 0));
      check("s_max",  24'(max_s),  24'(m_cnt[1] == MAXV));
      check("s_ceo",  24'(ceo_s),  24'(c & ~s & ~l & ~o & (d ? m_cnt[1] == MAXV : m_cnt[1] == 0)));
    end
    for (int i = 0; i < 2; i++) begin
      nov = 1'b0;
      nxt = m_cnt[i];
      if (!n)      nxt = 0;
      else if (s)  nxt = 0;
      else if (l)  nxt = sanit(v);
      else if (o)  nxt = 1;
      else if (c) begin
        if (d) begin
          if (m_cnt[i] == MAXV) begin nov = 1'b1; nxt = (i == 0) ? 0 : MAXV; end
          else nxt = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin nov = 1'b1; nxt = (i == 0) ? MAXV : 0; end
          else nxt = m_cnt[i] - 1;
        end
      end
      m_cnt[i] = nxt;
      if (i == 0) q_w.push_back({int2bcd(nxt), nov});
      else        q_s.push_back({int2bcd(nxt), nov});
    end
    if (!n) model_valid = 1'b1;
    @(posedge clk);
    #1;
    if (q_w.size() == 0 || q_s.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=%0d expected=1", q_w.size());
    end else begin
      e = q_w.pop_front();
      check("w_cnt", cnt_w, e[24:1]);
      check("w_ovf", 24'(ovf_w), 24'(e[0]));
      e = q_s.pop_front();
      check("s_cnt", cnt_s, e[24:1]);
      check("s_ovf", 24'(ovf_s), 24'(e[0]));
    end
  endtask

  initial begin
    nrst = 1'b1; ce = 1'b0; dir = 1'b0; sclr = 1'b0; set_one = 1'b0; load = 1'b0;
    load_val = '0;
    @(posedge clk);
    #1;
    // Reset with random side inputs.
    step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
         24'($urandom));
    // Hold for ten cycles.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 24'h0);
    // Up carry chain.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h099999);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    // Terminal up, hold (pulse must drop), terminal down.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h999999);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    // Down into zero, then sit there, then turn around.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000001);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    // Priority and load sanitising.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h555555);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h12A4F7);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0);
    // Control inputs suppress a terminal-event pulse.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'hFFFFFF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0);
    // Reset in the middle of counting.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000123);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h777777);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    // Mixed-direction walk with random direction on every step.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 24'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
